// File: rtl/ysyx_25040111_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word over imem req/ack, hands it to the IDU over valid/ready.
// Optional performance counters are enabled by defining YSYX_25040111_IFU_PERF_EN.
module ysyx_25040111_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fetch_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    WAIT  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (npc_valid) begin
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign fetch_err  = err_q;

`ifdef YSYX_25040111_IFU_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

  // Counters wrap naturally at 2^32
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == FETCH) begin
      if (imem_ack) fetch_cnt_d = fetch_cnt_q + XLEN'(1);
      else          stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
